// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg
//   Shared encodings for the PC-update sequencer: the PC operation codes
//   issued by main control, the PC source mux selects, the sequencer FSM
//   states, and the helper that maps an operation to its commit-time PC source.
//   Optional feature macro used by the sequencer: PC_ALIGN_CHECK_EN.
package pc_seq_pkg;

   typedef enum logic [2:0] {
      OP_NEXT = 3'b000,
      OP_BEQ  = 3'b001,
      OP_BNE  = 3'b010,
      OP_JUMP = 3'b011,
      OP_JR   = 3'b100,
      OP_RTE  = 3'b101,
      OP_EXC  = 3'b110,
      OP_RSVD = 3'b111
   } pc_op_e;

   typedef enum logic [1:0] {
      SRC_EPC    = 2'b00,
      SRC_ALU    = 2'b01,
      SRC_ALUOUT = 2'b10,
      SRC_CONCAT = 2'b11
   } pc_src_e;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      EVAL     = 3'd1,
      COMMIT   = 3'd2,
      EPC_SAVE = 3'd3,
      VEC_WAIT = 3'd4,
      DONE     = 3'd5
   } state_e;

   // PC mux select used while committing the given operation.
   // The exception vector arrives on ALUOut.
   function automatic pc_src_e commit_src(input pc_op_e op);
      pc_src_e src;
      case (op)
         OP_NEXT:        src = SRC_ALU;
         OP_BEQ, OP_BNE: src = SRC_ALUOUT;
         OP_JUMP:        src = SRC_CONCAT;
         OP_JR:          src = SRC_ALU;
         OP_RTE:         src = SRC_EPC;
         OP_EXC:         src = SRC_ALUOUT;
         default:        src = SRC_ALU;
      endcase
      return src;
   endfunction

endpackage

// File: rtl/pc_seq_timer.sv
// pc_seq_timer
//   4-bit loadable down-counter timing the exception-vector fetch wait.
//   Ports:
//     clk        in  system clock, rising edge
//     reset_n    in  asynchronous active-low reset (count -> 0)
//     load_i     in  load load_val_i into the counter (has priority over dec_i)
//     load_val_i in  value to load (1..15)
//     dec_i      in  decrement by one (saturates at 0)
//     expire_o   out counter currently holds 1, i.e. this is the last wait cycle
module pc_seq_timer (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       load_i,
   input  logic [3:0] load_val_i,
   input  logic       dec_i,
   output logic       expire_o
);

   logic [3:0] cnt_q;
   logic [3:0] cnt_d;

   // Next count: load wins over decrement; decrement never wraps below zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != 4'd0)) begin
         cnt_d = cnt_q - 4'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = (cnt_q == 4'd1);

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Multicycle PC-update controller. Accepts one PC operation per four-phase
//   req/done handshake, resolves branches from the ALU zero flag, sequences
//   exception entry (EPC save, vector wait, vector commit) and counts PC writes.
//   Optional feature macro: PC_ALIGN_CHECK_EN (misaligned-target trap).
//   Ports:
//     clk           in   system clock, rising edge
//     reset_n       in   asynchronous active-low reset
//     pc_req        in   operation request, held until done
//     pc_op         in   operation code, sampled on accept
//     alu_zero      in   ALU zero flag, used in EVAL
//     pc_next_lsb   in   PC mux output bits [1:0] (alignment check only)
//     pc_src        out  PC mux select (00 EPC, 01 ALU, 10 ALUOut, 11 Concat)
//     pc_write      out  PC load enable pulse
//     epc_write     out  EPC load enable pulse
//     busy          out  sequencer not idle
//     done          out  operation complete, held until pc_req drops
//     illegal       out  reserved op, valid with done
//     align_fault   out  misaligned target trapped, valid with done
//     commit_count  out  number of pc_write pulses since reset (wrapping)
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int VEC_WAIT_CYCLES = 2,  // legal range 1..15
   parameter int CNT_W           = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             pc_req,
   input  logic [2:0]       pc_op,
   input  logic             alu_zero,
   input  logic [1:0]       pc_next_lsb,
   output logic [1:0]       pc_src,
   output logic             pc_write,
   output logic             epc_write,
   output logic             busy,
   output logic             done,
   output logic             illegal,
   output logic             align_fault,
   output logic [CNT_W-1:0] commit_count
);

   localparam logic [3:0] VEC_LOAD = 4'(VEC_WAIT_CYCLES);

   state_e           state_q, state_d;
   pc_op_e           op_q, op_d;
   pc_src_e          pc_src_q, pc_src_d;
   logic             pc_write_q, pc_write_d;
   logic             epc_write_q, epc_write_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             illegal_q, illegal_d;
   logic             align_q, align_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic             tmr_load_s;
   logic             tmr_dec_s;
   logic             tmr_expire_s;
   logic             taken_s;
   logic             misalign_s;

   pc_seq_timer u_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_i     (tmr_load_s),
      .load_val_i (VEC_LOAD),
      .dec_i      (tmr_dec_s),
      .expire_o   (tmr_expire_s)
   );

   assign taken_s = ((op_q == OP_BEQ) &  alu_zero) |
                    ((op_q == OP_BNE) & ~alu_zero);

`ifdef PC_ALIGN_CHECK_EN
   // Checked in every COMMIT except the exception vector commit; once a trap
   // has been taken (align_q set) the vector commit is left unchecked so a bad
   // vector cannot trap forever.
   assign misalign_s = (state_q == COMMIT) && (op_q != OP_EXC) && !align_q &&
                       (pc_next_lsb != 2'b00);
`else
   logic unused_lsb_s;
   assign unused_lsb_s = ^pc_next_lsb;
   assign misalign_s   = 1'b0;
`endif

   // Next-state logic, plus output values decoded from the next state so the
   // registered outputs line up with the state they belong to.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      illegal_d  = illegal_q;
      align_d    = align_q;
      count_d    = count_q;
      tmr_load_s = 1'b0;
      tmr_dec_s  = 1'b0;

      case (state_q)
         IDLE: begin
            if (pc_req) begin
               op_d = pc_op_e'(pc_op);
               case (pc_op_e'(pc_op))
                  OP_NEXT, OP_JUMP, OP_JR, OP_RTE: state_d = COMMIT;
                  OP_BEQ, OP_BNE:                  state_d = EVAL;
                  OP_EXC:                          state_d = EPC_SAVE;
                  default: begin
                     state_d   = DONE;
                     illegal_d = 1'b1;
                  end
               endcase
            end else begin
               state_d = IDLE;
            end
         end
         EVAL: begin
            // Not-taken needs no write: fetch already loaded PC+4.
            if (taken_s) begin
               state_d = COMMIT;
            end else begin
               state_d = DONE;
            end
         end
         COMMIT: begin
            if (misalign_s) begin
               align_d = 1'b1;
               state_d = EPC_SAVE;
            end else begin
               count_d = count_q + CNT_W'(1);
               state_d = DONE;
            end
         end
         EPC_SAVE: begin
            tmr_load_s = 1'b1;
            state_d    = VEC_WAIT;
         end
         VEC_WAIT: begin
            tmr_dec_s = 1'b1;
            if (tmr_expire_s) begin
               state_d = COMMIT;
            end else begin
               state_d = VEC_WAIT;
            end
         end
         DONE: begin
            if (!pc_req) begin
               state_d   = IDLE;
               illegal_d = 1'b0;
               align_d   = 1'b0;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d   = IDLE;
            illegal_d = 1'b0;
            align_d   = 1'b0;
         end
      endcase

      pc_src_d    = SRC_ALU;
      pc_write_d  = 1'b0;
      epc_write_d = 1'b0;
      case (state_d)
         COMMIT: begin
            pc_write_d = 1'b1;
            // After an alignment trap the commit loads the vector from ALUOut.
            pc_src_d   = align_d ? SRC_ALUOUT : commit_src(op_d);
         end
         EPC_SAVE: begin
            epc_write_d = 1'b1;
         end
         default: begin
            pc_src_d = SRC_ALU;
         end
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // State, latched operation, flags, counter and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         op_q        <= OP_NEXT;
         pc_src_q    <= SRC_ALU;
         pc_write_q  <= 1'b0;
         epc_write_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         illegal_q   <= 1'b0;
         align_q     <= 1'b0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         pc_src_q    <= pc_src_d;
         pc_write_q  <= pc_write_d;
         epc_write_q <= epc_write_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         illegal_q   <= illegal_d;
         align_q     <= align_d;
         count_q     <= count_d;
      end
   end

   assign pc_src       = pc_src_q;
   // The alignment check sees the mux output only once COMMIT is under way,
   // so the suppression has to gate the registered pulse here.
   assign pc_write     = pc_write_q & ~misalign_s;
   assign epc_write    = epc_write_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign illegal      = illegal_q;
   assign align_fault  = align_q;
   assign commit_count = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//   Directed self-checking bench for pc_sequencer. Cycle 0 is the IDLE cycle in
//   which pc_req is first seen high; outputs are sampled on the falling edge of
//   each following cycle. A 4-bit commit counter keeps the wrap test short.
//   Optional feature macro exercised when defined: PC_ALIGN_CHECK_EN.
module tb_pc_sequencer;

   localparam int CNT_W = 4;

   logic             clk;
   logic             reset_n;
   logic             pc_req;
   logic [2:0]       pc_op;
   logic             alu_zero;
   logic [1:0]       pc_next_lsb;
   logic [1:0]       pc_src;
   logic             pc_write;
   logic             epc_write;
   logic             busy;
   logic             done;
   logic             illegal;
   logic             align_fault;
   logic [CNT_W-1:0] commit_count;

   int               n_cmp;
   int               n_err;
   logic [CNT_W-1:0] exp_cnt;

   pc_sequencer #(
      .VEC_WAIT_CYCLES (2),
      .CNT_W           (CNT_W)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .pc_req       (pc_req),
      .pc_op        (pc_op),
      .alu_zero     (alu_zero),
      .pc_next_lsb  (pc_next_lsb),
      .pc_src       (pc_src),
      .pc_write     (pc_write),
      .epc_write    (epc_write),
      .busy         (busy),
      .done         (done),
      .illegal      (illegal),
      .align_fault  (align_fault),
      .commit_count (commit_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One full handshake. pw_c/epc_c/done_c are the hand-computed cycles of the
   // pc_write pulse, epc_write pulse and first done (0 = never).
   task automatic do_op(input string tag, input logic [2:0] op, input logic zero,
                        input logic [1:0] lsb, input int pw_c, input logic [1:0] src_c,
                        input int epc_c, input int done_c, input logic ill);
      pc_op       = op;
      alu_zero    = zero;
      pc_next_lsb = lsb;
      pc_req      = 1'b1;
      for (int k = 1; k <= done_c; k++) begin
         step();
         pc_op = 3'b111;  // must be ignored while busy
         chk({tag, "_pcw"},  {31'd0, pc_write},  {31'd0, (k == pw_c)});
         chk({tag, "_epcw"}, {31'd0, epc_write}, {31'd0, (k == epc_c)});
         chk({tag, "_done"}, {31'd0, done},      {31'd0, (k == done_c)});
         chk({tag, "_busy"}, {31'd0, busy},      32'd1);
         chk({tag, "_src"},  {30'd0, pc_src},    {30'd0, (k == pw_c) ? src_c : 2'b01});
      end
      if (pw_c != 0) exp_cnt = exp_cnt + 4'd1;
      chk({tag, "_ill"},   {31'd0, illegal},     {31'd0, ill});
      chk({tag, "_align"}, {31'd0, align_fault}, 32'd0);
      chk({tag, "_cnt"},   {28'd0, commit_count}, {28'd0, exp_cnt});
      step();
      chk({tag, "_hold"},      {31'd0, done},     32'd1);
      chk({tag, "_hold_pcw"},  {31'd0, pc_write}, 32'd0);
      pc_req = 1'b0;
      step();
      chk({tag, "_rel_done"}, {31'd0, done},    32'd0);
      chk({tag, "_rel_busy"}, {31'd0, busy},    32'd0);
      chk({tag, "_rel_ill"},  {31'd0, illegal}, 32'd0);
      chk({tag, "_rel_src"},  {30'd0, pc_src},  32'd1);
   endtask

   initial begin
      n_cmp       = 0;
      n_err       = 0;
      exp_cnt     = 4'd0;
      reset_n     = 1'b0;
      pc_req      = 1'b0;
      pc_op       = 3'b000;
      alu_zero    = 1'b0;
      pc_next_lsb = 2'b00;

      repeat (2) @(negedge clk);
      chk("rst_src",  {30'd0, pc_src},       32'd1);
      chk("rst_pcw",  {31'd0, pc_write},     32'd0);
      chk("rst_epcw", {31'd0, epc_write},    32'd0);
      chk("rst_busy", {31'd0, busy},         32'd0);
      chk("rst_done", {31'd0, done},         32'd0);
      chk("rst_cnt",  {28'd0, commit_count}, 32'd0);
      reset_n = 1'b1;
      step();

      //    tag     op      zero  lsb    pw src    epc done ill
      do_op("next", 3'b000, 1'b0, 2'b00, 1, 2'b01, 0, 2, 1'b0);
      do_op("beqt", 3'b001, 1'b1, 2'b00, 2, 2'b10, 0, 3, 1'b0);
      do_op("bnen", 3'b010, 1'b1, 2'b00, 0, 2'b01, 0, 2, 1'b0);
      do_op("bnet", 3'b010, 1'b0, 2'b00, 2, 2'b10, 0, 3, 1'b0);
      do_op("beqn", 3'b001, 1'b0, 2'b00, 0, 2'b01, 0, 2, 1'b0);
`ifndef PC_ALIGN_CHECK_EN
      // Without the check a misaligned target commits normally.
      do_op("jump", 3'b011, 1'b0, 2'b10, 1, 2'b11, 0, 2, 1'b0);
`else
      do_op("jump", 3'b011, 1'b0, 2'b00, 1, 2'b11, 0, 2, 1'b0);
`endif
      do_op("jr",   3'b100, 1'b0, 2'b00, 1, 2'b01, 0, 2, 1'b0);
      do_op("rte",  3'b101, 1'b0, 2'b00, 1, 2'b00, 0, 2, 1'b0);
      do_op("exc",  3'b110, 1'b0, 2'b00, 4, 2'b10, 1, 5, 1'b0);
      do_op("rsvd", 3'b111, 1'b0, 2'b00, 0, 2'b01, 0, 1, 1'b1);
      chk("cnt_after_ops", {28'd0, commit_count}, 32'd7);

      // Early req drop: operation completes, done lasts a single cycle.
      pc_op  = 3'b000;
      pc_req = 1'b1;
      step();
      chk("pv_pcw", {31'd0, pc_write}, 32'd1);
      pc_req = 1'b0;
      step();
      chk("pv_done1", {31'd0, done}, 32'd1);
      step();
      chk("pv_done0", {31'd0, done}, 32'd0);
      chk("pv_busy0", {31'd0, busy}, 32'd0);
      chk("pv_cnt",   {28'd0, commit_count}, 32'd8);
      exp_cnt = 4'd8;

`ifdef PC_ALIGN_CHECK_EN
      // Misaligned JUMP: trap, EPC save, 2-cycle wait, unchecked vector commit.
      pc_op       = 3'b011;
      pc_next_lsb = 2'b10;
      pc_req      = 1'b1;
      step();
      chk("al_c1_pcw",  {31'd0, pc_write},  32'd0);
      chk("al_c1_src",  {30'd0, pc_src},    32'd3);
      step();
      chk("al_c2_epcw", {31'd0, epc_write}, 32'd1);
      chk("al_c2_src",  {30'd0, pc_src},    32'd1);
      chk("al_c2_cnt",  {28'd0, commit_count}, 32'd8);
      step();
      chk("al_c3_busy", {31'd0, busy},      32'd1);
      step();
      chk("al_c4_pcw",  {31'd0, pc_write},  32'd0);
      step();
      chk("al_c5_pcw",  {31'd0, pc_write},  32'd1);
      chk("al_c5_src",  {30'd0, pc_src},    32'd2);
      step();
      chk("al_c6_done", {31'd0, done},        32'd1);
      chk("al_c6_flag", {31'd0, align_fault}, 32'd1);
      chk("al_c6_cnt",  {28'd0, commit_count}, 32'd9);
      pc_req      = 1'b0;
      pc_next_lsb = 2'b00;
      step();
      chk("al_rel_flag", {31'd0, align_fault}, 32'd0);
      chk("al_rel_done", {31'd0, done},        32'd0);
`endif

      // Reset during VEC_WAIT of an exception.
      pc_op  = 3'b110;
      pc_req = 1'b1;
      step();
      step();
      step();
      chk("mr_inwait_busy", {31'd0, busy}, 32'd1);
      #1 reset_n = 1'b0;
      #1;
      chk("mr_src",  {30'd0, pc_src},       32'd1);
      chk("mr_busy", {31'd0, busy},         32'd0);
      chk("mr_pcw",  {31'd0, pc_write},     32'd0);
      chk("mr_epcw", {31'd0, epc_write},    32'd0);
      chk("mr_cnt",  {28'd0, commit_count}, 32'd0);
      pc_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         chk("mr_after_pulse", {31'd0, (pc_write | epc_write | busy)}, 32'd0);
      end
      exp_cnt = 4'd0;

      // Wrap: 15 commits reach all-ones, the 16th wraps to zero.
      for (int k = 0; k < 15; k++) begin
         do_op("wrap", 3'b000, 1'b0, 2'b00, 1, 2'b01, 0, 2, 1'b0);
      end
      chk("wrap_full", {28'd0, commit_count}, 32'd15);
      do_op("wrap0", 3'b000, 1'b0, 2'b00, 1, 2'b01, 0, 2, 1'b0);
      chk("wrap_zero", {28'd0, commit_count}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multicycle PC-update controller that drives the 4:1 PC source mux select (EPC / ALU_Result / ALUOut / Concat_28to32) and the PC/EPC write enables.
- Accepts one PC operation per request from the main control unit over a four-phase req/done handshake.
- Evaluates the branch condition from the ALU zero flag, sequences exception entry (EPC save, vector wait, vector load) and counts committed PC writes.

Parameters:
- VEC_WAIT_CYCLES, 2, cycles between EPC save and vector commit (memory latency of the vector fetch); legal range 1..15.
- CNT_W, 16, width of commit_count.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pc_req  in  1  request from main control; held high until done seen.
- pc_op  in  3  operation, sampled when accepted: 000 NEXT, 001 BEQ, 010 BNE, 011 JUMP, 100 JR, 101 RTE, 110 EXC, 111 reserved.
- alu_zero  in  1  ALU zero flag, valid in EVAL cycle.
- pc_next_lsb  in  2  bits [1:0] of the PC mux output (used only with the optional feature).
- pc_src  out  2  PC mux select: 00 EPC, 01 ALU_Result, 10 ALUOut, 11 Concat.
- pc_write  out  1  PC load enable, single-cycle pulse.
- epc_write  out  1  EPC load enable, single-cycle pulse.
- busy  out  1  high in every state except IDLE.
- done  out  1  operation complete; held until pc_req low.
- illegal  out  1  reserved op seen; valid while done is high.
- align_fault  out  1  misaligned target trapped; valid while done is high.
- commit_count  out  CNT_W  number of pc_write pulses since reset; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, reset_n=0): state IDLE, pc_src=01, all pulses/flags 0, commit_count=0, wait counter 0. Reset asserted mid-operation aborts with no further write pulses.
- IDLE: on pc_req=1, latch pc_op.
  - NEXT/JUMP/JR/RTE -> COMMIT.
  - BEQ/BNE -> EVAL.
  - EXC -> EPC_SAVE.
  - 111 -> DONE with illegal=1.
- EVAL (1 cycle): taken = (BEQ & alu_zero) | (BNE & ~alu_zero). Taken -> COMMIT; not-taken -> DONE with no pc_write (PC+4 was already written by the fetch NEXT).
- COMMIT (1 cycle): pc_write=1; commit_count += 1; then -> DONE. pc_src per op:
  - NEXT 01, BEQ/BNE 10, JUMP 11, JR 01, RTE 00, EXC 10 (vector on ALUOut).
- EPC_SAVE (1 cycle): epc_write=1, pc_src=01. Load wait counter with VEC_WAIT_CYCLES, -> VEC_WAIT.
- VEC_WAIT: decrement counter each cycle; at 1 -> COMMIT. Occupancy is exactly VEC_WAIT_CYCLES cycles.
- DONE: done=1; remain while pc_req=1; -> IDLE when pc_req=0. Flags illegal/align_fault clear on leaving DONE.
- Latency, IDLE accept edge to done: NEXT/JUMP/JR/RTE 2 cycles; BEQ/BNE taken 3, not-taken 2; EXC 3+VEC_WAIT_CYCLES; reserved op 1.
- pc_src is registered and stable for the whole state; returns to 01 outside COMMIT/EPC_SAVE.
- pc_op changes while busy are ignored. pc_req low before done (protocol violation) does not abort the operation; done then deasserts the cycle after it is raised.
- commit_count wraps from all-ones to 0 without a flag.

Optional Feature:
- Macro PC_ALIGN_CHECK_EN.
- Defined: in COMMIT for any op except EXC, if pc_next_lsb != 00 then suppress pc_write, do not increment commit_count, set align_fault, and -> EPC_SAVE (exception entry). The final vector COMMIT is unchecked, which prevents trap loops. done is then raised with align_fault=1.
- Undefined: pc_next_lsb ignored, align_fault tied 0.

Decomposition:
- Package pc_seq_pkg: pc_op encodings, pc_src encodings (SRC_EPC, SRC_ALU, SRC_ALUOUT, SRC_CONCAT), state enum (IDLE, EVAL, COMMIT, EPC_SAVE, VEC_WAIT, DONE).
- One sub-module pc_seq_timer: 4-bit loadable down-counter with load, dec and expire, used for VEC_WAIT.

Test Plan:
- Reset mid-VEC_WAIT (drop reset_n during EXC) -> outputs return to reset values immediately; no later epc_write/pc_write; commit_count=0.
- req NEXT -> pc_write pulse 1 cycle with pc_src=01; done 2 cycles after accept; commit_count 0->1; done holds until req drops.
- BEQ with alu_zero=1 -> pc_write with pc_src=10 at cycle 2; BNE with alu_zero=1 -> no pc_write, done at cycle 2, count unchanged.
- EXC with VEC_WAIT_CYCLES=2 -> epc_write at cycle 1, pc_write with pc_src=10 at cycle 4, done at cycle 5.
- pc_op=111 -> done and illegal after 1 cycle, no write pulses; RTE -> pc_write with pc_src=00.
- PC_ALIGN_CHECK_EN with JUMP and pc_next_lsb=10 -> no pc_write in COMMIT, epc_write next cycle, vector commit, done with align_fault=1, count +1. Also preload count to 0xFFFF, NEXT -> 0x0000.
